// File: rtl/four_digit_scan_ctrl_pkg.sv
// four_digit_scan_ctrl_pkg: shared FSM state type and BCD conversion sizes
package four_digit_scan_ctrl_pkg;
  typedef enum logic {IDLE, CONV} state_e;
  localparam int CONV_BITS = 12;
  localparam int BCD_W = 4;
  localparam int DIGITS = 4;
endpackage

// File: rtl/four_digit_scan_ctrl_if.sv
// four_digit_scan_ctrl_if: value request handshake and display outputs
interface four_digit_scan_ctrl_if;
  import four_digit_scan_ctrl_pkg::*;
  logic valid_i;
  logic [CONV_BITS-1:0] data_i;
  logic ready_o;
  logic neg_o;
  logic [DIGITS*BCD_W-1:0] digits_o;
  logic [DIGITS-1:0] an_o;
  logic [6:0] seg_o;
  modport master (output valid_i, data_i, input ready_o, neg_o, digits_o, an_o, seg_o);
  modport slave (input valid_i, data_i, output ready_o, neg_o, digits_o, an_o, seg_o);
endinterface

// File: rtl/four_digit_scan_ctrl_seven_segment.sv
// seven_segment: hex digit to active-low segment pattern {g,f,e,d,c,b,a}
module seven_segment (
  input  logic [3:0] num,
  output logic [6:0] data_o
);
  localparam logic [6:0] LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  assign data_o = LUT[num];
endmodule

// File: rtl/four_digit_scan_ctrl.sv
// four_digit_scan_ctrl: signed value to BCD via double dabble, multiplexed 4-digit scan
module four_digit_scan_ctrl
  import four_digit_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input logic clk_i,
  input logic rst_i,
  four_digit_scan_ctrl_if.slave bus
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = DIGITS * BCD_W;
  state_e state_q, state_d;
  logic [CONV_BITS-1:0] mag_q, mag_d;
  logic [BW-1:0] bcd_q, bcd_d, bcd_adj, bcd_sh, digits_q, digits_d;
  logic [3:0] cnt_q, cnt_d;
  logic sign_q, sign_d, neg_q, neg_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0] idx_q, idx_d;
  logic wrap;
  logic [DIGITS-1:0] blank;
  logic [BCD_W-1:0] nibble;
  logic [6:0] seg;
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++)
      bcd_adj[k*BCD_W +: BCD_W] = bcd_q[k*BCD_W +: BCD_W] >= 4'd5 ? bcd_q[k*BCD_W +: BCD_W] + 4'd3 : bcd_q[k*BCD_W +: BCD_W];
  end
  assign bcd_sh = {bcd_adj[BW-2:0], mag_q[CONV_BITS-1]};
  always_comb begin
    state_d = state_q;
    mag_d = mag_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    sign_d = sign_q;
    digits_d = digits_q;
    neg_d = neg_q;
    if (state_q == IDLE) begin
      if (bus.valid_i) begin
        state_d = CONV;
        mag_d = bus.data_i[CONV_BITS-1] ? -bus.data_i : bus.data_i;
        bcd_d = '0;
        cnt_d = '0;
        sign_d = bus.data_i[CONV_BITS-1];
      end
    end else begin
      bcd_d = bcd_sh;
      mag_d = {mag_q[CONV_BITS-2:0], 1'b0};
      cnt_d = cnt_q + 4'd1;
      // only the final shift is exposed, so partial BCD never reaches digits_o
      if (cnt_q == 4'(CONV_BITS - 1)) begin
        state_d = IDLE;
        digits_d = bcd_sh;
        neg_d = sign_q;
      end
    end
  end
  assign wrap = pre_q == PW'(SCAN_DIV - 1);
  assign pre_d = wrap ? '0 : pre_q + 1'b1;
  assign idx_d = wrap ? idx_q + 2'd1 : idx_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mag_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      sign_q <= 1'b0;
      digits_q <= '0;
      neg_q <= 1'b0;
      pre_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      mag_q <= mag_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      sign_q <= sign_d;
      digits_q <= digits_d;
      neg_q <= neg_d;
      pre_q <= pre_d;
      idx_q <= idx_d;
    end
  end
  assign blank[3] = BLANK_LZ != 0 && digits_q[15:12] == '0;
  assign blank[2] = blank[3] && digits_q[11:8] == '0;
  assign blank[1] = blank[2] && digits_q[7:4] == '0;
  assign blank[0] = 1'b0;
  assign nibble = digits_q[{idx_q, 2'b00} +: BCD_W];
  seven_segment u_seg (.num(nibble), .data_o(seg));
  assign bus.ready_o = state_q == IDLE;
  assign bus.neg_o = neg_q;
  assign bus.digits_o = digits_q;
  assign bus.an_o = blank[idx_q] ? 4'b1111 : ~(4'b0001 << idx_q);
  assign bus.seg_o = seg;
endmodule

// File: doc/four_digit_scan_ctrl.md
FOUR_DIGIT_SCAN_CTRL -- requirements
Module: four_digit_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000, SHALL set the number of clk_i cycles each digit is driven (legal range 1..2^20).
REQ-002 Parameter BLANK_LZ, default 1, SHALL enable leading-zero blanking when 1.
REQ-003 clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  SHALL be the synchronous, active-high reset.
REQ-005 valid_i  in  1  SHALL be the request qualifier for data_i.
REQ-006 data_i  in  12  SHALL be the value to display, two's complement (-2048..2047).
REQ-007 ready_o  out  1  SHALL be high when a new value can be accepted.
REQ-008 neg_o  out  1  SHALL be the sign of the committed value (1 = negative).
REQ-009 digits_o  out  16  SHALL be the committed BCD digits {thousands, hundreds, tens, ones}.
REQ-010 an_o  out  4  SHALL be the one-hot, active-low digit enable; an_o[3] = thousands, an_o[0] = ones.
REQ-011 seg_o  out  7  SHALL be the segment pattern of the currently enabled digit.

Function
REQ-012 Acceptance SHALL occur on a rising edge where valid_i && ready_o; valid_i while ready_o=0 SHALL be ignored, with no queuing.
REQ-013 On acceptance, the block SHALL latch the magnitude |data_i| as 12-bit unsigned; -2048 -> 2048; 0 -> 0 with sign positive.
REQ-014 FSM states SHALL be IDLE (ready_o=1) and CONV (ready_o=0); IDLE->CONV on acceptance; CONV->IDLE after 12 shift cycles.
REQ-015 CONV SHALL perform iterative shift-add-3 (double dabble): one magnitude bit per cycle, MSB first, with add-3 to every BCD nibble >=5 before each shift; no divide or modulo operators.
REQ-016 digits_o and neg_o SHALL update only on the 12th CONV edge (12 edges after the acceptance edge), with ready_o returning to 1 on that same edge; intermediate BCD state SHALL never appear on digits_o.
REQ-017 Throughput SHALL be one value per 13 cycles: a new acceptance is possible on the edge after ready_o rises.
REQ-018 The scan prescaler SHALL count 0..SCAN_DIV-1; on wrap, the digit index SHALL advance 0->1->2->3->0 (ones, tens, hundreds, thousands).
REQ-019 an_o SHALL drive low exactly the bit of the current index; seg_o SHALL be the encoding of digits_o nibble [index].
REQ-020 With BLANK_LZ=1, a digit SHALL be blanked (its an_o bit held high, all an_o = 4'b1111 for that slot) when it and all more-significant digits are 0; the ones digit SHALL never be blanked.
REQ-021 Scanning SHALL run continuously, independent of the FSM; a commit mid-slot SHALL take effect on seg_o on the next edge without restarting the prescaler.
REQ-022 neg_o SHALL be an output only; sign indication on a segment is out of scope.

Reset
REQ-023 When rst_i=1 at an edge: state IDLE, ready_o=1, neg_o=0, digits_o=16'h0000, prescaler 0, index 0, an_o=4'b1110, seg_o = encoding of 0.
REQ-024 Reset during CONV SHALL abort conversion and discard the partial result; valid_i SHALL be ignored while rst_i=1.

Structure
REQ-025 A shared package SHALL hold the FSM state typedef, the conversion bit count (12), and the BCD digit width (4).
REQ-026 Segment encoding SHALL be done by one instance of the existing seven_segment sub-module (num 4-bit in, data_o 7-bit out); no other sub-module.
REQ-027 Scan prescaler width SHALL be derived as clog2(SCAN_DIV), minimum 1 bit.

Verification
REQ-028 Reset, then valid_i=1 with data_i=1234 -> ready_o low for 12 cycles, digits_o=16'h1234, neg_o=0 on the 12th edge.
REQ-029 data_i=-2048 (12'h800) -> digits_o=16'h2048, neg_o=1; data_i=-1 -> 16'h0001, neg_o=1; data_i=0 -> 16'h0000, neg_o=0.
REQ-030 SCAN_DIV=4, value 7: an_o sequence 1110 (seg=enc(7)), then 1111 three slots, 4 cycles each; with BLANK_LZ=0 -> 1110,1101,1011,0111 with seg enc(7),enc(0),enc(0),enc(0).
REQ-031 valid_i held high with data_i changing every cycle -> exactly one acceptance per 13 cycles; committed values equal data_i sampled at each acceptance edge.
REQ-032 rst_i asserted on the 5th CONV cycle of 999 -> next edge ready_o=1, digits_o=16'h0000, an_o=4'b1110; no later commit of 999.
REQ-033 Commit of 2047 mid-slot while index=2 -> seg_o shows enc(0) on the following edge; prescaler count unchanged.
